// File: rtl/pong_engine.sv
// pong_engine: frame-stepped Pong game logic driven by an external raster position.
// Optional feature macro PONG_MISS_DETECT_EN enables miss detection, lives and game over.
module pong_engine #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int BALL_SIZE      = 16,
    parameter int PADDLE_W       = 112,
    parameter int PADDLE_STEP    = 64,
    parameter int PADDLE_Y       = 432,
    parameter int HITS_PER_LEVEL = 8,
    parameter int SPEED_MAX      = 4,
    parameter int LIVES          = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       left,
    input  logic       right,
    input  logic       serve,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       inDisplayArea,
    output logic       vga_R,
    output logic       vga_G,
    output logic       vga_B,
    output logic [7:0] oLed,
    output logic       game_over
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [9:0]  BALL_X_MAX  = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [8:0]  BALL_Y_MAX  = 9'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  PAD_MAX     = 10'(SCREEN_W - PADDLE_W);
    localparam logic [9:0]  PAD_CTR     = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0]  PAD_STEP    = 10'(PADDLE_STEP);
    localparam logic [10:0] PAD_W       = 11'(PADDLE_W);
    localparam logic [9:0]  PAD_Y0      = 10'(PADDLE_Y);
    localparam logic [9:0]  PAD_Y1      = 10'(PADDLE_Y + 16);
    localparam logic [9:0]  SERVE_X     = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0]  SERVE_Y     = 9'd64;
    localparam logic [8:0]  TICK_Y      = 9'(SCREEN_H + 20);
    localparam logic [10:0] BORDER_X_HI = 11'(SCREEN_W - 8);
    localparam logic [9:0]  BORDER_Y_HI = 10'(SCREEN_H - 8);
    localparam logic [10:0] BALL_W      = 11'(BALL_SIZE);
    localparam logic [9:0]  BALL_H      = 10'(BALL_SIZE);
    localparam logic [10:0] HALF_W      = 11'(BALL_SIZE / 2);
    localparam logic [9:0]  HALF_H      = 10'(BALL_SIZE / 2);

    state_t      state_r, stateNext_s;
    logic [9:0]  paddleX_r, ballX_r, ballXNext_s;
    logic [8:0]  ballY_r, ballYNext_s;
    logic        dirX_r, dirY_r, dirXNext_s, dirYNext_s;
    logic [3:0]  speed_r;
    logic [7:0]  lives_r, oLedNext_s;
    logic        ignoreTick_r, frameTick_s, tickValid_s, missEvent_s;
    logic        colL_r, colR_r, colT_r, colB_r, hitPaddle_r;
    logic [10:0] px_s, bx_s, sumX_s, padSum_s;
    logic [9:0]  py_s, by_s, sumY_s;
    logic        isBorder_s, isPaddle_s, isBall_s, solid_s;
    logic        atLeft_s, atRight_s, atTop_s, atBot_s;

    function automatic logic [3:0] speedFor(input logic [7:0] hits);
        int lvl;
        lvl = 1 + int'(hits) / HITS_PER_LEVEL;
        if (lvl > SPEED_MAX) begin
            lvl = SPEED_MAX;
        end else begin
            lvl = lvl;
        end
        return 4'(lvl);
    endfunction

    assign frameTick_s = (CounterX == 10'd0) && (CounterY == TICK_Y);
    assign tickValid_s = frameTick_s && !ignoreTick_r;

    assign px_s = {1'b0, CounterX};
    assign py_s = {1'b0, CounterY};
    assign bx_s = {1'b0, ballX_r};
    assign by_s = {1'b0, ballY_r};

    assign isBorder_s = (px_s < 11'd8) || (px_s >= BORDER_X_HI) || (py_s < 10'd8) || (py_s >= BORDER_Y_HI);
    assign isPaddle_s = (px_s >= {1'b0, paddleX_r}) && (px_s < {1'b0, paddleX_r} + PAD_W) &&
                        (py_s >= PAD_Y0) && (py_s < PAD_Y1);
    assign isBall_s   = (px_s >= bx_s) && (px_s < bx_s + BALL_W) && (py_s >= by_s) && (py_s < by_s + BALL_H);
    assign solid_s    = isBorder_s || isPaddle_s;
    assign atLeft_s   = (px_s == bx_s) && (py_s == by_s + HALF_H);
    assign atRight_s  = (px_s == bx_s + BALL_W - 11'd1) && (py_s == by_s + HALF_H);
    assign atTop_s    = (px_s == bx_s + HALF_W) && (py_s == by_s);
    assign atBot_s    = (px_s == bx_s + HALF_W) && (py_s == by_s + BALL_H - 10'd1);

`ifdef PONG_MISS_DETECT_EN
    logic hitFloor_r;

    // Bottom-wall contact of the ball's lower midpoint, latched over one frame
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hitFloor_r <= 1'b0;
        end else if (frameTick_s) begin
            hitFloor_r <= 1'b0;
        end else if (inDisplayArea) begin
            hitFloor_r <= hitFloor_r | (atBot_s & (py_s >= BORDER_Y_HI));
        end
    end

    assign missEvent_s = (state_r == PLAY) && tickValid_s && hitFloor_r && !hitPaddle_r;
`else
    assign missEvent_s = 1'b0;
`endif

    // Edge-collision flags, accumulated during the raster and cleared each frame
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            colL_r      <= 1'b0;
            colR_r      <= 1'b0;
            colT_r      <= 1'b0;
            colB_r      <= 1'b0;
            hitPaddle_r <= 1'b0;
        end else if (frameTick_s) begin
            colL_r      <= 1'b0;
            colR_r      <= 1'b0;
            colT_r      <= 1'b0;
            colB_r      <= 1'b0;
            hitPaddle_r <= 1'b0;
        end else if (inDisplayArea) begin
            colL_r      <= colL_r | (atLeft_s & solid_s);
            colR_r      <= colR_r | (atRight_s & solid_s);
            colT_r      <= colT_r | (atTop_s & solid_s);
            colB_r      <= colB_r | (atBot_s & solid_s);
            hitPaddle_r <= hitPaddle_r | (atBot_s & isPaddle_s);
        end
    end

    // Game state register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic; button transitions act immediately, frame transitions on the tick
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE:  stateNext_s = SERVE;
            SERVE: stateNext_s = serve ? PLAY : SERVE;
            PLAY:  stateNext_s = missEvent_s ? MISS : PLAY;
            MISS: begin
                if (tickValid_s) begin
                    stateNext_s = (lives_r != 8'd0) ? SERVE : OVER;
                end else begin
                    stateNext_s = MISS;
                end
            end
            OVER:    stateNext_s = serve ? SERVE : OVER;
            default: stateNext_s = IDLE;
        endcase
    end

    // Score, lives, speed, game-over flag and the post-reset tick mask
    always_comb begin
        oLedNext_s = oLed;
        if ((state_r == PLAY) && tickValid_s && hitPaddle_r && (oLed != 8'd255)) begin
            oLedNext_s = oLed + 8'd1;
        end else if ((state_r == OVER) && serve) begin
            oLedNext_s = 8'd0;
        end else begin
            oLedNext_s = oLed;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            oLed         <= 8'd0;
            lives_r      <= 8'(LIVES);
            speed_r      <= 4'd1;
            game_over    <= 1'b0;
            ignoreTick_r <= 1'b1;
        end else begin
            oLed      <= oLedNext_s;
            game_over <= (stateNext_s == OVER);
            if (frameTick_s) begin
                ignoreTick_r <= 1'b0;
            end
            if (missEvent_s && (lives_r != 8'd0)) begin
                lives_r <= lives_r - 8'd1;
            end else if ((state_r == OVER) && serve) begin
                lives_r <= 8'(LIVES);
            end
            if (state_r == SERVE) begin
                speed_r <= 4'd1;
            end else if ((state_r == PLAY) && tickValid_s) begin
                speed_r <= speedFor(oLedNext_s);
            end
        end
    end

    // Next ball position: single-side contact turns the ball away, two-side contact freezes the axis
    always_comb begin
        dirXNext_s  = dirX_r;
        dirYNext_s  = dirY_r;
        ballXNext_s = ballX_r;
        ballYNext_s = ballY_r;
        sumX_s      = bx_s + {7'd0, speed_r};
        sumY_s      = by_s + {6'd0, speed_r};
        if (colL_r && colR_r) begin
            ballXNext_s = ballX_r;
        end else begin
            if (colL_r) begin
                dirXNext_s = 1'b1;
            end else if (colR_r) begin
                dirXNext_s = 1'b0;
            end else begin
                dirXNext_s = dirX_r;
            end
            if (dirXNext_s) begin
                ballXNext_s = (sumX_s > {1'b0, BALL_X_MAX}) ? BALL_X_MAX : sumX_s[9:0];
            end else begin
                ballXNext_s = (bx_s < {7'd0, speed_r}) ? 10'd0 : ballX_r - {6'd0, speed_r};
            end
        end
        if (colT_r && colB_r) begin
            ballYNext_s = ballY_r;
        end else begin
            if (colT_r) begin
                dirYNext_s = 1'b1;
            end else if (colB_r) begin
                dirYNext_s = 1'b0;
            end else begin
                dirYNext_s = dirY_r;
            end
            if (dirYNext_s) begin
                ballYNext_s = (sumY_s > {1'b0, BALL_Y_MAX}) ? BALL_Y_MAX : sumY_s[8:0];
            end else begin
                ballYNext_s = (by_s < {6'd0, speed_r}) ? 9'd0 : ballY_r - {5'd0, speed_r};
            end
        end
    end

    // Ball register: parked at the serve spot until play starts
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            ballX_r <= SERVE_X;
            ballY_r <= SERVE_Y;
            dirX_r  <= 1'b1;
            dirY_r  <= 1'b1;
        end else if ((state_r == SERVE) || (state_r == IDLE)) begin
            ballX_r <= SERVE_X;
            ballY_r <= SERVE_Y;
            dirX_r  <= 1'b1;
            dirY_r  <= 1'b1;
        end else if ((state_r == PLAY) && tickValid_s) begin
            ballX_r <= ballXNext_s;
            ballY_r <= ballYNext_s;
            dirX_r  <= dirXNext_s;
            dirY_r  <= dirYNext_s;
        end
    end

    assign padSum_s = {1'b0, paddleX_r} + {1'b0, PAD_STEP};

    // Paddle movement with clamping; simultaneous left and right cancel
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            paddleX_r <= PAD_CTR;
        end else if (left && !right) begin
            paddleX_r <= (paddleX_r < PAD_STEP) ? 10'd0 : paddleX_r - PAD_STEP;
        end else if (right && !left) begin
            paddleX_r <= (padSum_s > {1'b0, PAD_MAX}) ? PAD_MAX : padSum_s[9:0];
        end
    end

    // Registered pixel colour: border white, ball yellow, paddle blue
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            vga_R <= 1'b0;
            vga_G <= 1'b0;
            vga_B <= 1'b0;
        end else begin
            vga_R <= inDisplayArea & (isBorder_s | isBall_s);
            vga_G <= inDisplayArea & (isBorder_s | isBall_s);
            vga_B <= inDisplayArea & (isBorder_s | isPaddle_s);
        end
    end
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed self-checking bench for pong_engine (default geometry).
// Build with +define+PONG_MISS_DETECT_EN to exercise the lives/game-over path.
`timescale 1ns/1ps
module tb_pong_engine;
    logic       clk = 1'b0;
    logic       Reset, left, right, serve, inDisplayArea;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       vga_R, vga_G, vga_B, game_over;
    logic [7:0] oLed;
    logic [2:0] rgb;
    int         assertCount = 0;
    int         failCount = 0;
    int         bx, by;

    assign rgb = {vga_R, vga_G, vga_B};

    always #5 clk = ~clk;

    pong_engine dut (
        .clk(clk), .Reset(Reset), .left(left), .right(right), .serve(serve),
        .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B), .oLed(oLed), .game_over(game_over)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One raster cycle at (x,y), then back to an idle off-screen position
    task automatic drive(input int x, input int y, input logic da);
        @(negedge clk);
        CounterX = 10'(x);
        CounterY = 9'(y);
        inDisplayArea = da;
        @(negedge clk);
        CounterX = 10'd700;
        CounterY = 9'd0;
        inDisplayArea = 1'b0;
    endtask

    task automatic tick();
        drive(0, 500, 1'b0);
    endtask

    task automatic pulse(input logic l, input logic r, input logic s);
        @(negedge clk);
        left = l;
        right = r;
        serve = s;
        @(negedge clk);
        left = 1'b0;
        right = 1'b0;
        serve = 1'b0;
    endtask

`ifdef PONG_MISS_DETECT_EN
    task automatic missRound(input int livesAfter);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (99) tick();
        checkVal("miss round ballY", 32'(dut.ballY_r), 32'd457);
        drive(632, 472, 1'b1);
        tick();
        checkVal("miss round lives", 32'(dut.lives_r), 32'(livesAfter));
        checkVal("miss round state MISS", 32'(dut.state_r), 32'd3);
    endtask
`endif

    initial begin
        Reset = 1'b0;
        left = 1'b0;
        right = 1'b0;
        serve = 1'b0;
        CounterX = 10'd700;
        CounterY = 9'd0;
        inDisplayArea = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("reset oLed", 32'(oLed), 32'd0);
        checkVal("reset rgb", 32'(rgb), 32'd0);
        checkVal("reset game_over", 32'(game_over), 32'd0);
        checkVal("reset paddle", 32'(dut.paddleX_r), 32'd264);
        checkVal("reset lives", 32'(dut.lives_r), 32'd3);
        checkVal("reset speed", 32'(dut.speed_r), 32'd1);
        checkVal("reset state", 32'(dut.state_r), 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        checkVal("release state SERVE", 32'(dut.state_r), 32'd1);

        pulse(1'b1, 1'b0, 1'b0);
        checkVal("one left", 32'(dut.paddleX_r), 32'd200);
        pulse(1'b1, 1'b1, 1'b0);
        checkVal("left+right cancel", 32'(dut.paddleX_r), 32'd200);
        repeat (20) pulse(1'b1, 1'b0, 1'b0);
        checkVal("left clamp", 32'(dut.paddleX_r), 32'd0);
        repeat (20) pulse(1'b0, 1'b1, 1'b0);
        checkVal("right clamp", 32'(dut.paddleX_r), 32'd528);

        pulse(1'b0, 1'b0, 1'b1);
        checkVal("serve to PLAY", 32'(dut.state_r), 32'd2);
        tick();
        checkVal("ignored tick X", 32'(dut.ballX_r), 32'd312);
        checkVal("ignored tick Y", 32'(dut.ballY_r), 32'd64);
        tick();
        checkVal("first move X", 32'(dut.ballX_r), 32'd313);
        checkVal("first move Y", 32'(dut.ballY_r), 32'd65);
        repeat (367) tick();
        checkVal("descent X clamp", 32'(dut.ballX_r), 32'd624);
        checkVal("descent Y", 32'(dut.ballY_r), 32'd432);

        // Ball sits exactly in the paddle band: top and bottom contact freeze Y, bottom scores
        for (int i = 1; i <= 40; i++) begin
            drive(632, 432, 1'b1);
            drive(632, 447, 1'b1);
            tick();
            if (i == 8) begin
                checkVal("8 hits oLed", 32'(oLed), 32'd8);
                checkVal("8 hits speed", 32'(dut.speed_r), 32'd2);
            end
            if (i == 24) begin
                checkVal("24 hits speed", 32'(dut.speed_r), 32'd4);
            end
        end
        checkVal("40 hits oLed", 32'(oLed), 32'd40);
        checkVal("40 hits speed", 32'(dut.speed_r), 32'd4);
        checkVal("frozen Y", 32'(dut.ballY_r), 32'd432);

        repeat (20) pulse(1'b1, 1'b0, 1'b0);
        checkVal("paddle to 0", 32'(dut.paddleX_r), 32'd0);
        repeat (7) tick();
        checkVal("fall Y", 32'(dut.ballY_r), 32'd460);
        drive(632, 475, 1'b1);
        tick();
`ifdef PONG_MISS_DETECT_EN
        checkVal("miss1 lives", 32'(dut.lives_r), 32'd2);
        checkVal("miss1 state MISS", 32'(dut.state_r), 32'd3);
        tick();
        checkVal("miss1 to SERVE", 32'(dut.state_r), 32'd1);
        checkVal("serve Y", 32'(dut.ballY_r), 32'd64);
        missRound(1);
        tick();
        checkVal("miss2 to SERVE", 32'(dut.state_r), 32'd1);
        missRound(0);
        tick();
        checkVal("OVER state", 32'(dut.state_r), 32'd4);
        checkVal("game_over high", 32'(game_over), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        checkVal("restart oLed", 32'(oLed), 32'd0);
        checkVal("restart lives", 32'(dut.lives_r), 32'd3);
        checkVal("restart state", 32'(dut.state_r), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        bx = 312;
        by = 64;
`else
        checkVal("bounce Y", 32'(dut.ballY_r), 32'd456);
        checkVal("bounce dirY up", 32'(dut.dirY_r), 32'd0);
        checkVal("bounce state PLAY", 32'(dut.state_r), 32'd2);
        checkVal("bounce game_over", 32'(game_over), 32'd0);
        checkVal("bounce oLed", 32'(oLed), 32'd40);
        bx = 624;
        by = 456;
`endif

        drive(bx + 2, by + 4, 1'b1);
        checkVal("ball pixel", 32'(rgb), 32'd6);
        drive(bx + 2, by + 4, 1'b0);
        checkVal("ball pixel blanked", 32'(rgb), 32'd0);
        drive(0, 0, 1'b1);
        checkVal("border pixel", 32'(rgb), 32'd7);
        drive(50, 440, 1'b1);
        checkVal("paddle pixel", 32'(rgb), 32'd1);
        drive(300, 200, 1'b1);
        checkVal("empty pixel", 32'(rgb), 32'd0);

        @(negedge clk);
        CounterX = 10'(bx + 2);
        CounterY = 9'(by + 4);
        inDisplayArea = 1'b1;
        @(posedge clk);
        #2;
        checkVal("rgb before reset", 32'(rgb), 32'd6);
        Reset = 1'b0;
        #1;
        checkVal("async reset oLed", 32'(oLed), 32'd0);
        checkVal("async reset rgb", 32'(rgb), 32'd0);
        checkVal("async reset state", 32'(dut.state_r), 32'd0);
        checkVal("async reset paddle", 32'(dut.paddleX_r), 32'd264);
        checkVal("async reset game_over", 32'(game_over), 32'd0);
        @(negedge clk);
        CounterX = 10'd700;
        CounterY = 9'd0;
        inDisplayArea = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        checkVal("re-release SERVE", 32'(dut.state_r), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 480, visible pixel rows.
REQ-003 SHALL have parameter BALL_SIZE, default 16, ball edge length in pixels, power of two.
REQ-004 SHALL have parameter PADDLE_W, default 112, paddle width in pixels.
REQ-005 SHALL have parameter PADDLE_STEP, default 64, paddle displacement per button pulse.
REQ-006 SHALL have parameter PADDLE_Y, default 432, top row of the 16-row paddle band.
REQ-007 SHALL have parameter HITS_PER_LEVEL, default 8, paddle hits per speed level.
REQ-008 SHALL have parameter SPEED_MAX, default 4, maximum ball speed in pixels per frame.
REQ-009 SHALL have parameter LIVES, default 3, misses allowed before game over.
REQ-010 SHALL have ports: clk in 1, system clock; Reset in 1, asynchronous active-low reset.
REQ-011 SHALL have ports: left in 1, right in 1, serve in 1, debounced single-cycle button pulses.
REQ-012 SHALL have ports: CounterX in 10, CounterY in 9, inDisplayArea in 1, raster position from the sync generator.
REQ-013 SHALL have ports: vga_R, vga_G, vga_B out 1 each, registered pixel colour.
REQ-014 SHALL have ports: oLed out 8, hit score; game_over out 1, high while in OVER.

Function
REQ-015 SHALL generate frame_tick for one cycle when CounterX==0 and CounterY==SCREEN_H+20; all ball and state updates occur only on frame_tick.
REQ-016 SHALL implement FSM IDLE -> SERVE on reset release; SERVE -> PLAY on serve pulse; PLAY -> MISS on miss; MISS -> SERVE on the next frame_tick if lives>0, else -> OVER; OVER -> SERVE on serve pulse, reloading lives and clearing score.
REQ-017 SHALL, in SERVE, hold the ball centred horizontally at row 64 with dirY down and dirX right, and speed 1.
REQ-018 SHALL move the paddle by PADDLE_STEP on each left or right pulse in any state; ignore the pulse when left and right arrive in the same cycle; clamp to [0, SCREEN_W-PADDLE_W].
REQ-019 SHALL latch the four edge-collision flags (left, right, top, bottom midpoints of the ball) against border or paddle pixels during the raster and clear them on frame_tick.
REQ-020 SHALL, on frame_tick in PLAY, move the ball by speed in X and Y; reverse a direction on its single-side collision; freeze that axis when both sides collide.
REQ-021 SHALL increment oLed on each frame with a bottom-midpoint paddle collision; oLed saturates at 255.
REQ-022 SHALL set speed = min(1 + oLed/HITS_PER_LEVEL, SPEED_MAX).
REQ-023 SHALL draw a white 8-pixel border, the paddle and the ball; SHALL gate every colour with inDisplayArea and register it, giving 1-cycle latency.
REQ-024 SHALL clamp the ball position so it never leaves [0, SCREEN_W-BALL_SIZE] x [0, SCREEN_H-BALL_SIZE].

Reset
REQ-025 SHALL, on Reset low, asynchronously clear score, flags, and colour outputs; set the paddle centred, lives=LIVES, speed=1, game_over=0, and state=IDLE.
REQ-026 SHALL abort any in-flight frame update on Reset; the first frame_tick after release SHALL be ignored.

Configuration
REQ-027 SHALL honour macro PONG_MISS_DETECT_EN: when defined, a bottom-wall collision without a paddle collision in the same frame is a miss, decrementing lives and entering MISS.
REQ-028 SHALL, without PONG_MISS_DETECT_EN, bounce the ball off the bottom wall; MISS and OVER are unreachable and game_over stays 0.

Verification
REQ-029 Reset low mid-PLAY -> oLed=0, vga_*=0, state IDLE, and the paddle centred within one cycle, independent of clk.
REQ-030 Hold left for 20 pulses from centre -> paddle=0 and does not underflow; 20 right pulses -> paddle=SCREEN_W-PADDLE_W.
REQ-031 Ball on paddle for 8 consecutive frames -> oLed=8 and speed=2; at oLed=24, speed=4 and stays 4 at oLed=40.
REQ-032 With PONG_MISS_DETECT_EN defined, paddle at 0, ball falls at X=600 -> lives 3->2, state SERVE; after 3 misses -> game_over=1; serve pulse -> oLed=0, lives=3.
REQ-033 Without the macro, the same stimulus -> ball reverses at the bottom wall and game_over stays 0.
REQ-034 Same-cycle left and right pulses -> paddle unchanged; inDisplayArea=0 over a ball pixel -> vga_*=0 one cycle later.
